// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: operation select encodings.
package shift_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_bit_counter.sv
// Frame counter: counts shifts, wraps after WIDTH of them and pulses frame_done on the wrap.
module shift_bit_counter #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // inc and clr come from one mode value and never coincide; clr wins regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (clr) begin
                bit_cnt <= '0;
            end else if (inc) begin
                if (bit_cnt == LAST) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / parallel load) with
// a frame counter that flags every WIDTH completed shifts.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  mode_t            mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_done
);

    logic [WIDTH-1:0] q;
    logic             inc;
    logic             clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (mode)
                MODE_SHR:  q <= {sin_r, q[WIDTH-1:1]};
                MODE_SHL:  q <= {q[WIDTH-2:0], sin_l};
                MODE_LOAD: q <= pin;
                default:   q <= q;
            endcase
        end
    end

    // Direction is irrelevant to framing; any shift advances the count.
    assign inc = (mode == MODE_SHR) || (mode == MODE_SHL);
    assign clr = (mode == MODE_LOAD);

    shift_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .inc        (inc),
        .clr        (clr),
        .bit_cnt    (bit_cnt),
        .frame_done (frame_done)
    );

    assign pout   = q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed-vector bench for univ_shift_reg at WIDTH=4 with hand-computed expectations.
module tb_univ_shift_reg;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pout;
    logic             sout_r;
    logic             sout_l;
    logic [CNT_W-1:0] bit_cnt;
    logic             frame_done;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SHR  = 2'b01;
    localparam logic [1:0] SHL  = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pin        (pin),
        .pout       (pout),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .bit_cnt    (bit_cnt),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [3:0] e_pout,
                          input logic [2:0] e_cnt, input logic e_fd);
        chk({tag, ".pout"}, 64'(pout), 64'(e_pout));
        chk({tag, ".cnt"},  64'(bit_cnt), 64'(e_cnt));
        chk({tag, ".fd"},   64'(frame_done), 64'(e_fd));
    endtask

    task automatic chk_cnt(input string tag, input logic [2:0] e_cnt, input logic e_fd);
        chk({tag, ".cnt"}, 64'(bit_cnt), 64'(e_cnt));
        chk({tag, ".fd"},  64'(frame_done), 64'(e_fd));
    endtask

    // Apply one vector, take one edge, settle away from the edge.
    task automatic step(input logic r, input logic [1:0] m, input logic sr,
                        input logic sl, input logic [3:0] p);
        rst   = r;
        mode  = m;
        sin_r = sr;
        sin_l = sl;
        pin   = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mode = LOAD; sin_r = 1'b0; sin_l = 1'b0; pin = 4'hF;
        #1;

        // 1. reset dominates LOAD
        step(1, LOAD, 0, 0, 4'hF); chk_st("rst1", 4'h0, 0, 0);
        chk("rst1.sout_r", 64'(sout_r), 64'd0);
        chk("rst1.sout_l", 64'(sout_l), 64'd0);
        step(1, LOAD, 0, 0, 4'hF); chk_st("rst2", 4'h0, 0, 0);
        step(0, LOAD, 0, 0, 4'hF); chk_st("load_f", 4'hF, 0, 0);

        // 2. load
        step(0, LOAD, 0, 0, 4'b1010); chk_st("load_a", 4'b1010, 0, 0);
        chk("load_a.sout_r", 64'(sout_r), 64'd0);
        chk("load_a.sout_l", 64'(sout_l), 64'd1);

        // 3. serial in, right shift
        step(1, HOLD, 0, 0, 4'h0); chk_st("rst3", 4'h0, 0, 0);
        step(0, SHR, 1, 0, 4'h0); chk_st("shr1", 4'b1000, 1, 0);
        chk("shr1.sout_r", 64'(sout_r), 64'd0);
        step(0, SHR, 0, 0, 4'h0); chk_st("shr2", 4'b0100, 2, 0);
        chk("shr2.sout_r", 64'(sout_r), 64'd0);
        step(0, SHR, 1, 0, 4'h0); chk_st("shr3", 4'b1010, 3, 0);
        chk("shr3.sout_r", 64'(sout_r), 64'd0);
        step(0, SHR, 1, 0, 4'h0); chk_st("shr4", 4'b1101, 0, 1);
        chk("shr4.sout_r", 64'(sout_r), 64'd1);

        // 4. parallel in, left shift out
        step(0, LOAD, 0, 0, 4'b0001); chk_st("ld1", 4'b0001, 0, 0);
        step(0, SHL, 0, 0, 4'h0); chk_st("shl1", 4'b0010, 1, 0);
        chk("shl1.sout_l", 64'(sout_l), 64'd0);
        step(0, SHL, 0, 0, 4'h0); chk_st("shl2", 4'b0100, 2, 0);
        chk("shl2.sout_l", 64'(sout_l), 64'd0);
        step(0, SHL, 0, 0, 4'h0); chk_st("shl3", 4'b1000, 3, 0);
        chk("shl3.sout_l", 64'(sout_l), 64'd1);
        step(0, SHL, 0, 0, 4'h0); chk_st("shl4", 4'b0000, 0, 1);
        chk("shl4.sout_l", 64'(sout_l), 64'd0);

        // 5. hold mid-frame
        step(0, SHR, 1, 0, 4'h0); chk_st("h_shr1", 4'b1000, 1, 0);
        step(0, SHR, 1, 0, 4'h0); chk_st("h_shr2", 4'b1100, 2, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, HOLD, 0, 1, 4'hF); chk_st("h_hold", 4'b1100, 2, 0);
        end
        step(0, SHR, 0, 0, 4'h0); chk_st("h_shr3", 4'b0110, 3, 0);
        step(0, SHR, 0, 0, 4'h0); chk_st("h_shr4", 4'b0011, 0, 1);
        step(0, SHR, 0, 0, 4'h0); chk_cnt("b2b1", 1, 0);
        step(0, SHR, 0, 0, 4'h0); chk_cnt("b2b2", 2, 0);
        step(0, SHR, 0, 0, 4'h0); chk_cnt("b2b3", 3, 0);
        step(0, SHR, 0, 0, 4'h0); chk_cnt("b2b4", 0, 1);
        step(0, HOLD, 0, 0, 4'h0); chk_cnt("b2b_hold", 0, 0);

        // 6a. reset aborts a frame
        step(0, SHR, 1, 0, 4'h0); chk_cnt("ab_r1", 1, 0);
        step(0, SHR, 1, 0, 4'h0); chk_cnt("ab_r2", 2, 0);
        step(0, SHR, 1, 0, 4'h0); chk_cnt("ab_r3", 3, 0);
        step(1, SHR, 1, 0, 4'h0); chk_st("ab_rst", 4'h0, 0, 0);
        step(0, SHR, 1, 0, 4'h0); chk_cnt("ab_rn1", 1, 0);
        step(0, SHR, 1, 0, 4'h0); chk_cnt("ab_rn2", 2, 0);
        step(0, SHR, 1, 0, 4'h0); chk_cnt("ab_rn3", 3, 0);
        step(0, SHR, 1, 0, 4'h0); chk_st("ab_rn4", 4'hF, 0, 1);

        // 6b. load aborts a frame
        step(0, SHR, 0, 0, 4'h0); chk_cnt("ab_l1", 1, 0);
        step(0, SHR, 0, 0, 4'h0); chk_cnt("ab_l2", 2, 0);
        step(0, SHR, 0, 0, 4'h0); chk_cnt("ab_l3", 3, 0);
        step(0, LOAD, 0, 0, 4'h5); chk_st("ab_ld", 4'h5, 0, 0);
        step(0, SHR, 0, 0, 4'h0); chk_st("ab_ln1", 4'b0010, 1, 0);
        step(0, SHR, 0, 0, 4'h0); chk_cnt("ab_ln2", 2, 0);
        step(0, SHR, 0, 0, 4'h0); chk_cnt("ab_ln3", 3, 0);
        step(0, SHR, 0, 0, 4'h0); chk_cnt("ab_ln4", 0, 1);

        // mixed directions within one frame
        step(0, LOAD, 0, 0, 4'b0110); chk_st("mx_ld", 4'b0110, 0, 0);
        step(0, SHL, 0, 1, 4'h0); chk_st("mx1", 4'b1101, 1, 0);
        step(0, SHR, 0, 0, 4'h0); chk_st("mx2", 4'b0110, 2, 0);
        step(0, SHL, 0, 0, 4'h0); chk_st("mx3", 4'b1100, 3, 0);
        step(0, SHR, 1, 0, 4'h0); chk_st("mx4", 4'b1110, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
